// File: rtl/iob_fifo2axis.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : iob_fifo2axis                                              |
// | Description : Drain stage from a 1-cycle-latency synchronous FIFO read   |
// |               port to an AXI-Stream master. A 2-entry output buffer      |
// |               hides the FIFO read latency so the stream can sustain one  |
// |               beat per cycle. A programmable beat counter generates      |
// |               tlast for fixed-length frames (len_i = 0: no tlast).       |
// | Optional    : `define IOB_FIFO2AXIS_CNT_EN adds beats_o, a 32-bit        |
// |               wrapping count of accepted AXIS beats.                     |
// | Ports       : clk_i, rst_n_i (sync, active-low)                          |
// |               en_i, len_i           - read enable / frame length         |
// |               r_en_o, r_data_i, r_empty_i - FIFO read port               |
// |               axis_tvalid_o, axis_tready_i, axis_tdata_o, axis_tlast_o   |
// |               beats_o (only with IOB_FIFO2AXIS_CNT_EN)                   |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
module iob_fifo2axis #(
  parameter int DATA_W = 32,
  parameter int LEN_W  = 16
) (
  input  logic              clk_i,
  input  logic              rst_n_i,
  input  logic              en_i,
  input  logic [LEN_W-1:0]  len_i,
  output logic              r_en_o,
  input  logic [DATA_W-1:0] r_data_i,
  input  logic              r_empty_i,
  output logic              axis_tvalid_o,
  input  logic              axis_tready_i,
  output logic [DATA_W-1:0] axis_tdata_o,
  output logic              axis_tlast_o
`ifdef IOB_FIFO2AXIS_CNT_EN
  ,
  output logic [31:0]       beats_o
`endif
);

  localparam logic [LEN_W-1:0] c_len_one = LEN_W'(1);

  // Buffer: entry 0 is the head, entry 1 the tail slot behind it.
  logic [DATA_W-1:0] r_data0, r_data1;
  logic              r_last0, r_last1;
  logic [1:0]        r_occ;
  logic              r_tvalid;
  logic              r_inflight;
  logic              r_inflight_last;
  logic [LEN_W-1:0]  r_cnt;

  logic              w_pop;
  logic [2:0]        w_fill;
  logic              w_is_last;
  logic [1:0]        w_occ_popped;
  logic [1:0]        w_occ_n;
  logic [DATA_W-1:0] w_data0_n, w_data1_n;
  logic              w_last0_n, w_last1_n;

  assign w_pop  = r_tvalid & axis_tready_i;
  assign w_fill = {1'b0, r_occ} + {2'b00, r_inflight};

  // A read may be issued when there is a free slot for the returning word,
  // counting the word already in flight; a pop this cycle frees one slot.
  assign r_en_o = rst_n_i & en_i & ~r_empty_i & ((w_fill < 3'd2) | w_pop);

  // The last flag is decided when the read is issued, so that the counter
  // follows issued reads rather than accepted beats.
  assign w_is_last = (len_i != '0) && (r_cnt == (len_i - c_len_one));

  always_comb begin
    w_data0_n    = r_data0;
    w_data1_n    = r_data1;
    w_last0_n    = r_last0;
    w_last1_n    = r_last1;
    w_occ_popped = r_occ - {1'b0, w_pop};
    if (w_pop) begin
      w_data0_n = r_data1;
      w_last0_n = r_last1;
    end
    // The returning word lands in the first free slot after the pop.
    if (r_inflight) begin
      if (w_occ_popped == 2'd0) begin
        w_data0_n = r_data_i;
        w_last0_n = r_inflight_last;
      end else begin
        w_data1_n = r_data_i;
        w_last1_n = r_inflight_last;
      end
    end
    w_occ_n = w_occ_popped + {1'b0, r_inflight};
  end

  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      r_data0         <= '0;
      r_data1         <= '0;
      r_last0         <= 1'b0;
      r_last1         <= 1'b0;
      r_occ           <= 2'd0;
      r_tvalid        <= 1'b0;
      r_inflight      <= 1'b0;
      r_inflight_last <= 1'b0;
      r_cnt           <= '0;
    end else begin
      r_data0         <= w_data0_n;
      r_data1         <= w_data1_n;
      r_last0         <= w_last0_n;
      r_last1         <= w_last1_n;
      r_occ           <= w_occ_n;
      r_tvalid        <= (w_occ_n != 2'd0);
      r_inflight      <= r_en_o;
      r_inflight_last <= r_en_o & w_is_last;
      if (len_i == '0) begin
        r_cnt <= '0;
      end else if (r_en_o) begin
        r_cnt <= w_is_last ? '0 : (r_cnt + c_len_one);
      end
    end
  end

  assign axis_tvalid_o = r_tvalid;
  assign axis_tdata_o  = r_data0;
  // The head slot may hold a stale flag once drained; hide it while idle.
  assign axis_tlast_o  = r_last0 & r_tvalid;

`ifdef IOB_FIFO2AXIS_CNT_EN
  logic [31:0] r_beats;

  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      r_beats <= 32'd0;
    end else if (w_pop) begin
      r_beats <= r_beats + 32'd1;
    end
  end

  assign beats_o = r_beats;
`endif

endmodule
`default_nettype wire

// File: tb/tb_iob_fifo2axis.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : tb_iob_fifo2axis                                           |
// | Description : Self-checking bench for iob_fifo2axis with a behavioural   |
// |               1-cycle-latency FIFO model and a table of stream scenarios.|
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
module tb_iob_fifo2axis;

  localparam int DATA_W = 32;
  localparam int LEN_W  = 16;

  logic              clk    = 1'b0;
  logic              rst_n  = 1'b0;
  logic              en     = 1'b0;
  logic [LEN_W-1:0]  len    = '0;
  logic              r_en;
  logic [DATA_W-1:0] r_data = '0;
  logic              r_empty;
  logic              tvalid;
  logic              tready = 1'b0;
  logic [DATA_W-1:0] tdata;
  logic              tlast;
`ifdef IOB_FIFO2AXIS_CNT_EN
  logic [31:0]       beats;
`endif

  always #5 clk = ~clk;

  iob_fifo2axis #(.DATA_W(DATA_W), .LEN_W(LEN_W)) dut (
    .clk_i         (clk),
    .rst_n_i       (rst_n),
    .en_i          (en),
    .len_i         (len),
    .r_en_o        (r_en),
    .r_data_i      (r_data),
    .r_empty_i     (r_empty),
    .axis_tvalid_o (tvalid),
    .axis_tready_i (tready),
    .axis_tdata_o  (tdata),
    .axis_tlast_o  (tlast)
`ifdef IOB_FIFO2AXIS_CNT_EN
    ,
    .beats_o       (beats)
`endif
  );

  // Behavioural FIFO: write side owned by the stimulus, read side by the clock.
  logic [DATA_W-1:0] mem [0:4095];
  int wr_ptr = 0;
  int rd_ptr = 0;
  assign r_empty = (wr_ptr == rd_ptr);

  always @(posedge clk) begin
    if (r_en) begin
      r_data <= mem[rd_ptr[11:0]];
      rd_ptr <= rd_ptr + 1;
    end
  end

  typedef struct {
    int len;
    int nwords;
    int ready_pct;
    int dis_at;
    int dis_len;
    int exp_lasts;
  } scen_t;

  scen_t tbl [6];
  int checks  = 0;
  int errors  = 0;
  int wr_val  = 0;
  int exp_val = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h @%0t", name, act, exp, $time);
    end
  endtask

  task automatic load(input int n);
    for (int k = 0; k < n; k++) begin
      mem[wr_ptr[11:0]] = DATA_W'(wr_val);
      wr_val++;
      wr_ptr++;
    end
  endtask

  task automatic run_scen(input int idx, input scen_t s);
    int  rx, lasts, cyc, first_v, last_beat, ren_bad, dis_left, dis_beats, limit;
    bit  dis_done, prev_stall, exp_l;
    logic [DATA_W-1:0] prev_d;
    logic prev_l;
    rx = 0; lasts = 0; cyc = 0; first_v = -1; last_beat = -1; ren_bad = 0;
    dis_left = 0; dis_beats = 0; dis_done = 0; prev_stall = 0;
    prev_d = '0; prev_l = 1'b0;
    limit = s.nwords * 6 + 100;
    len = LEN_W'(s.len);
    while (rx < s.nwords && cyc < limit) begin
      @(negedge clk);
      if (s.dis_len > 0 && !dis_done && rx == s.dis_at) begin
        dis_left  = s.dis_len;
        dis_done  = 1;
        dis_beats = 0;
      end
      en     = (dis_left == 0);
      tready = ($urandom_range(0, 99) < s.ready_pct);
      #1;
      if (r_en && r_empty) ren_bad++;
      if (tvalid && first_v < 0) first_v = cyc;
      if (prev_stall)
        chk($sformatf("s%0d_hold", idx), {tvalid, tlast, tdata}, {1'b1, prev_l, prev_d});
      prev_stall = tvalid && !tready;
      prev_d     = tdata;
      prev_l     = tlast;
      if (tvalid && tready) begin
        exp_l = (s.len != 0) ? (((rx + 1) % s.len) == 0) : 1'b0;
        chk($sformatf("s%0d_data%0d", idx, rx), tdata, DATA_W'(exp_val));
        chk($sformatf("s%0d_last%0d", idx, rx), tlast, exp_l);
        if (tlast) lasts++;
        rx++;
        exp_val++;
        last_beat = cyc;
        if (dis_left > 0) dis_beats++;
      end
      if (dis_left > 0) begin
        dis_left--;
        if (dis_left == 0) begin
          chk($sformatf("s%0d_drain_beats_le2", idx), (dis_beats <= 2), 1);
          chk($sformatf("s%0d_drain_idle", idx), tvalid, 0);
        end
      end
      cyc++;
    end
    chk($sformatf("s%0d_rx_count", idx), rx, s.nwords);
    chk($sformatf("s%0d_tlast_count", idx), lasts, s.exp_lasts);
    chk($sformatf("s%0d_ren_while_empty", idx), ren_bad, 0);
    chk($sformatf("s%0d_first_valid_lat", idx), first_v, 2);
    if (s.ready_pct == 100 && s.dis_len == 0)
      chk($sformatf("s%0d_span", idx), last_beat - first_v + 1, s.nwords);
    @(negedge clk);
    en = 1'b0;
    #1;
`ifdef IOB_FIFO2AXIS_CNT_EN
    chk($sformatf("s%0d_beats_o", idx), beats, s.nwords);
`endif
    @(negedge clk);
    #1;
    chk($sformatf("s%0d_idle_after", idx), tvalid, 0);
    rst_n = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    //        len nwords pct dis_at dis_len exp_lasts
    tbl[0] = '{0, 1024, 100, 0, 0, 0};
    tbl[1] = '{4,   16, 100, 0, 0, 4};
    tbl[2] = '{1,    8, 100, 0, 0, 8};
    tbl[3] = '{4,   64,  50, 0, 0, 16};
    tbl[4] = '{8,   24, 100, 3, 5, 3};
    tbl[5] = '{3,   30,  70, 0, 0, 10};

    // Reset with a non-empty FIFO and enable high.
    load(tbl[0].nwords);
    rst_n  = 1'b0;
    en     = 1'b1;
    tready = 1'b1;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      #1;
      chk($sformatf("rst%0d_r_en", c), r_en, 0);
      chk($sformatf("rst%0d_tvalid", c), tvalid, 0);
      chk($sformatf("rst%0d_tlast", c), tlast, 0);
      chk($sformatf("rst%0d_tdata", c), tdata, 0);
    end
    @(negedge clk);
    en    = 1'b0;
    rst_n = 1'b1;
    @(negedge clk);
    chk("rst_no_reads", rd_ptr, 0);

    for (int i = 0; i < 6; i++) begin
      if (i > 0) begin
        @(negedge clk);
        load(tbl[i].nwords);
      end
      run_scen(i, tbl[i]);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
